// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the strobe bundle carried
// through the sync/blank alignment delay line.
package vga_timing_pkg;

    localparam int H_VISIBLE  = 640;
    localparam int H_FRONT    = 16;
    localparam int H_SYNC     = 96;
    localparam int H_BACK     = 48;
    localparam int V_VISIBLE  = 480;
    localparam int V_FRONT    = 10;
    localparam int V_SYNC     = 2;
    localparam int V_BACK     = 33;
    localparam int SYNC_DELAY = 2;

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } vga_strobe_t;

    // Idle strobe state: syncs deasserted (high), outside the visible region.
    localparam vga_strobe_t STROBE_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-gated shift register that lines hs/vs/blank up with the
// registered ROM/palette/RGB pipeline of the renderers.
module vga_sync_delay
    import vga_timing_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  vga_strobe_t rst_val,
    input  vga_strobe_t din,
    output vga_strobe_t dout
);

    if (DEPTH < 1 || DEPTH > 4) begin : g_depth_chk
        $error("vga_sync_delay: DEPTH must be 1..4");
    end

    vga_strobe_t [DEPTH-1:0] pipe;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pipe <= {DEPTH{rst_val}};
        end else if (en) begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing master: scan counters, delayed sync/blank strobes,
// line/frame start pulses and a free-running frame counter.
module vga_timing_gen
    import vga_timing_pkg::vga_strobe_t;
#(
    parameter int H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT    = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int H_BACK     = vga_timing_pkg::H_BACK,
    parameter int V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT    = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int V_BACK     = vga_timing_pkg::V_BACK,
    parameter int SYNC_DELAY = vga_timing_pkg::SYNC_DELAY
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_chk
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must fit 10-bit counters");
    end

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    logic [9:0]  hc, vc;
    logic        h_wrap, v_wrap;
    vga_strobe_t raw, dly;

    assign h_wrap = (hc == H_LAST);
    assign v_wrap = (vc == V_LAST);

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            hc          <= '0;
            vc          <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            // Pulses are re-evaluated every clock so they never stretch
            // across stalled (pix_en=0) cycles.
            line_start  <= pix_en && h_wrap;
            frame_start <= pix_en && h_wrap && v_wrap;
            if (pix_en) begin
                hc <= h_wrap ? '0 : hc + 10'd1;
                if (h_wrap) begin
                    vc <= v_wrap ? '0 : vc + 10'd1;
                end
                if (h_wrap && v_wrap) begin
                    frame_count <= frame_count + 8'd1;
                end
            end
        end
    end

    always_comb begin
        raw.hs    = !((hc >= 10'(HS_START)) && (hc < 10'(HS_END)));
        raw.vs    = !((vc >= 10'(VS_START)) && (vc < 10'(VS_END)));
        raw.blank = (hc < 10'(H_VISIBLE)) && (vc < 10'(V_VISIBLE));
    end

    vga_sync_delay #(
        .DEPTH (SYNC_DELAY)
    ) u_sync_delay (
        .clk     (vga_clk),
        .reset_n (reset_n),
        .en      (pix_en),
        .rst_val (vga_timing_pkg::STROBE_IDLE),
        .din     (raw),
        .dout    (dly)
    );

    assign DrawX = hc;
    assign DrawY = vc;
    assign hs    = dly.hs;
    assign vs    = dly.vs;
    assign blank = dly.blank;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default timing, SYNC_DELAY=4, and a shrunken
// timing so whole frames and frame_count wrap fit a short run.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic pix_en = 1'b1;

    always #5 clk = ~clk;

    logic [9:0] dx_a, dy_a, dx_b, dy_b, dx_c, dy_c;
    logic       hs_a, vs_a, bl_a, ls_a, fs_a;
    logic       hs_b, vs_b, bl_b, ls_b, fs_b;
    logic       hs_c, vs_c, bl_c, ls_c, fs_c;
    logic [7:0] fc_a, fc_b, fc_c;

    vga_timing_gen u_def (
        .vga_clk(clk), .reset_n(reset_n), .pix_en(pix_en),
        .DrawX(dx_a), .DrawY(dy_a), .hs(hs_a), .vs(vs_a), .blank(bl_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
    );

    vga_timing_gen #(.SYNC_DELAY(4)) u_d4 (
        .vga_clk(clk), .reset_n(reset_n), .pix_en(pix_en),
        .DrawX(dx_b), .DrawY(dy_b), .hs(hs_b), .vs(vs_b), .blank(bl_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_small (
        .vga_clk(clk), .reset_n(reset_n), .pix_en(pix_en),
        .DrawX(dx_c), .DrawY(dy_c), .hs(hs_c), .vs(vs_c), .blank(bl_c),
        .line_start(ls_c), .frame_start(fs_c), .frame_count(fc_c)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit armed = 1'b0;

    // Model state: pixel ticks since reset, and whether the last edge ticked.
    longint t = 0;
    bit ticked = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            t      <= 0;
            ticked <= 1'b0;
        end else begin
            ticked <= pix_en;
            if (pix_en) t <= t + 1;
        end
    end

    // Expected {DrawX, DrawY, hs, vs, blank, line_start, frame_start, frame_count}
    // straight from the tick count: position is t mod line/frame length,
    // strobes are those of the position d ticks ago (idle before that).
    function automatic logic [32:0] model_out(int hv, int hf, int hsw, int hb,
                                              int vv, int vf, int vsw, int vb,
                                              int d, longint tt, bit tk);
        longint ht = hv + hf + hsw + hb;
        longint vt = vv + vf + vsw + vb;
        longint ft = ht * vt;
        longint x  = tt % ht;
        longint y  = (tt / ht) % vt;
        longint kx, ky;
        logic e_hs, e_vs, e_bl, e_ls, e_fs;
        logic [7:0] e_fc;
        if (tt < d) begin
            e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0;
        end else begin
            kx = (tt - d) % ht;
            ky = ((tt - d) / ht) % vt;
            e_hs = !(kx >= hv + hf && kx < hv + hf + hsw);
            e_vs = !(ky >= vv + vf && ky < vv + vf + vsw);
            e_bl = (kx < hv) && (ky < vv);
        end
        e_ls = tk && (x == 0);
        e_fs = tk && (tt % ft == 0);
        e_fc = 8'((tt / ft) % 256);
        return {10'(x), 10'(y), e_hs, e_vs, e_bl, e_ls, e_fs, e_fc};
    endfunction

    task automatic cmp(string name, logic [32:0] act, logic [32:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d: got %h expected %h", name, t, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            cmp("model_def", {dx_a, dy_a, hs_a, vs_a, bl_a, ls_a, fs_a, fc_a},
                model_out(640, 16, 96, 48, 480, 10, 2, 33, 2, t, ticked));
            cmp("model_d4", {dx_b, dy_b, hs_b, vs_b, bl_b, ls_b, fs_b, fc_b},
                model_out(640, 16, 96, 48, 480, 10, 2, 33, 4, t, ticked));
            cmp("model_small", {dx_c, dy_c, hs_c, vs_c, bl_c, ls_c, fs_c, fc_c},
                model_out(8, 2, 3, 2, 6, 1, 2, 1, 2, t, ticked));
        end
    end

    task automatic chk(string name, longint act, longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int cur = 0;
    task automatic go(int c);
        repeat (c - cur) @(posedge clk);
        #2;
        cur = c;
    endtask

    int hs_lo_a, hs_lo_b, ls_cnt;

    initial begin
        reset_n = 1'b0;
        pix_en  = 1'b1;
        @(posedge clk);
        #2 armed = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        cur = 0;

        // Reset release, pix_en held high; cycle 0 is the reset state.
        chk("c0_drawx", dx_a, 0);
        chk("c0_hs", hs_a, 1);
        chk("c0_blank", bl_a, 0);
        chk("c0_fcount", fc_a, 0);
        go(1);    chk("c1_blank", bl_a, 0);
        go(2);    chk("c2_blank", bl_a, 1);
                  chk("c2_drawx_d4", dx_b, 2);
        go(106);  chk("small_c106_vs", vs_c, 1);
        go(107);  chk("small_c107_vs", vs_c, 0);
        go(149);  chk("small_c149_fs", fs_c, 0);
                  chk("small_c149_fc", fc_c, 0);
        go(150);  chk("small_c150_fs", fs_c, 1);
                  chk("small_c150_fc", fc_c, 1);
        go(151);  chk("small_c151_fs", fs_c, 0);
        go(641);  chk("c641_blank", bl_a, 1);
        go(642);  chk("c642_blank", bl_a, 0);
        go(657);  chk("c657_hs", hs_a, 1);
        go(658);  chk("c658_hs", hs_a, 0);
        go(659);  chk("c659_hs_d4", hs_b, 1);
                  chk("c659_drawx_d4", dx_b, 659);
        go(660);  chk("c660_hs_d4", hs_b, 0);
        go(753);  chk("c753_hs", hs_a, 0);
        go(754);  chk("c754_hs", hs_a, 1);

        // Line boundary 5 -> 6.
        go(4798); chk("c4798_drawx", dx_a, 798); chk("c4798_drawy", dy_a, 5);
        go(4799); chk("c4799_drawx", dx_a, 799); chk("c4799_ls", ls_a, 0);
        go(4800); chk("c4800_drawx", dx_a, 0);   chk("c4800_drawy", dy_a, 6);
                  chk("c4800_ls", ls_a, 1);
        go(4801); chk("c4801_ls", ls_a, 0);

        // 256 frames of the small timing: frame_count wraps to 0.
        go(38399); chk("small_fc255", fc_c, 255);
        go(38400); chk("small_fc_wrap", fc_c, 0);
                   chk("small_fs_wrap", fs_c, 1);
                   chk("c38400_drawx", dx_a, 0);

        // pix_en 1,0,1,0 over one full default line.
        hs_lo_a = 0; hs_lo_b = 0; ls_cnt = 0;
        for (int i = 0; i < 1600; i++) begin
            pix_en = (i % 2 == 0);
            @(posedge clk);
            #2;
            if (!hs_a) hs_lo_a++;
            if (!hs_b) hs_lo_b++;
            if (ls_a) ls_cnt++;
        end
        chk("toggle_hs_width", hs_lo_a, 192);
        chk("toggle_hs_width_d4", hs_lo_b, 192);
        chk("toggle_ls_count", ls_cnt, 1);
        pix_en = 1'b1;

        // Mid-frame reset while the small instance shows blank=1.
        chk("pre_rst_drawx", dx_c, 5);
        chk("pre_rst_drawy", dy_c, 3);
        chk("pre_rst_blank", bl_c, 1);
        reset_n = 1'b0;
        @(posedge clk);
        #2;
        chk("rst_drawx", dx_c, 0);
        chk("rst_drawy", dy_c, 0);
        chk("rst_blank", bl_c, 0);
        chk("rst_hs", hs_c, 1);
        chk("rst_vs", vs_c, 1);
        chk("rst_fs", fs_c, 0);
        chk("rst_fcount", fc_a, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #2;
        chk("rel_fs", fs_c, 0);
        chk("rel_ls", ls_c, 0);
        chk("rel_drawx", dx_c, 1);
        repeat (200) @(posedge clk);
        #2;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Pixel-timing master for the VGA display path. Generates the scan coordinates DrawX/DrawY used by the sprite/ROM renderers, and the hs/vs/blank strobes those renderers consume.
- Sync and blank outputs are delayed by a programmable number of pixel ticks. This aligns them with the registered ROM-then-palette-then-RGB pipeline downstream.
- Also provides line/frame start pulses and a frame counter for game-logic and animation timing.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels); H_TOTAL = 800
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines); V_TOTAL = 525
- SYNC_DELAY, 2, pipeline depth applied to hs/vs/blank (legal range 1..4)

Ports:
- vga_clk  in  1  pixel-domain clock
- reset_n  in  1  synchronous, active-low reset
- pix_en  in  1  pixel tick enable; counters and delay line advance only when 1
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1 (undelayed, ROM address side)
- DrawY  out  10  current vertical count, 0..V_TOTAL-1 (undelayed)
- hs  out  1  horizontal sync, active low, delayed by SYNC_DELAY ticks
- vs  out  1  vertical sync, active low, delayed by SYNC_DELAY ticks
- blank  out  1  1 = visible region (renderer drives color), delayed by SYNC_DELAY ticks
- line_start  out  1  one-vga_clk pulse when hc wraps to 0
- frame_start  out  1  one-vga_clk pulse when (hc,vc) wraps to (0,0)
- frame_count  out  8  frames completed since reset, mod 256

Behaviour:
- Reset (reset_n=0 at a vga_clk edge):
  - hc = vc = 0
  - hs = vs = 1, blank = 0
  - every delay-line stage is filled with (hs=1, vs=1, blank=0)
  - line_start = frame_start = 0, frame_count = 0
- Reset asserted mid-frame returns to this state on the next edge. No partial line is completed.
- Counters: on an edge with pix_en=1:
  - hc <= (hc==H_TOTAL-1) ? 0 : hc+1
  - when hc wraps: vc <= (vc==V_TOTAL-1) ? 0 : vc+1
  - pix_en=0 holds all state, including the delay line and frame_count.
- DrawX = hc and DrawY = vc, registered, zero-extended to 10 bits. Values above 639/479 appear during blanking; consumers gate with blank.
- Raw strobes (combinational from hc/vc):
  - hs_raw = 0 iff H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751
  - vs_raw = 0 iff vc in 490..491
  - blank_raw = (hc < H_VISIBLE) && (vc < V_VISIBLE)
- Delay line: SYNC_DELAY-stage shift register of {hs_raw, vs_raw, blank_raw}, shifting only on pix_en. Outputs come from the last stage.
- line_start: registered. It is 1 for exactly one vga_clk cycle, the cycle following a pix_en edge on which hc wrapped. If pix_en is low the next cycle, it still drops after one cycle.
- frame_start: same rule, for the edge on which both hc and vc wrap.
  - Neither pulse fires on reset release: (0,0) is entered by reset, not by a wrap.
- frame_count increments on the edge where frame_start is set; 255 wraps to 0.
- Arithmetic: hc and vc are 10-bit unsigned. H_TOTAL and V_TOTAL must be <= 1024 (elaboration-time assertion).

Decomposition:
- Package vga_timing_pkg holds:
  - the default H/V timing constants
  - derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END
  - typedef vga_strobe_t, a packed struct {hs, vs, blank}
- One sub-module, vga_sync_delay: parameterized depth-N enable-gated shift register of vga_strobe_t, with a reset value input.

Test Plan:
- Reset release with pix_en=1 held:
  - hc=0 on cycle 0
  - hs falls at cycle 658 and rises at cycle 754
  - blank high on cycles 2..641 of line 0, low again at 642
- Full frame with pix_en=1:
  - vs low for exactly 1600 pixel ticks, starting at tick 392002
  - frame_start first pulses at tick 420000
  - frame_count becomes 1 on that edge and reads 0 after 256 frames
- Line boundary:
  - DrawX sequence 798, 799, 0 with DrawY 5 → 6
  - line_start high for one cycle coincident with DrawX=0
- pix_en toggling 1,0,1,0: counters advance every other cycle, hs low width is 192 vga_clk cycles, and pulses stay one cycle wide.
- Reset asserted at (hc=300, vc=200) while blank=1: next edge gives hc=vc=0, blank=0, hs=vs=1, and no frame_start.
- Parameterization with SYNC_DELAY=4: the hs falling edge moves to cycle 660, while DrawX timing is unchanged.
